// File: rtl/gcn_sram_stream_ctrl.sv
// gcn_sram_stream_ctrl
//   Front-end for one single-port SRAM macro (512x128 by default) used as a
//   GCN feature/weight buffer. A write stream and a read-address stream share
//   the macro port, one access per cycle. The macro's registered read data is
//   captured into a small output FIFO that presents a valid/ready stream.
//
//   Optional feature macro: GCN_SRAM_STATS_EN (accepted write/read counters).
//
// Ports
//   clk, rst                   clock (also macro CE), synchronous active-high reset
//   wr_valid/wr_ready          write request handshake, wr_addr/wr_data payload
//   rd_valid/rd_ready          read request handshake, rd_addr payload
//   rdata_valid/rdata_ready    read-data stream out of the FIFO, rdata payload
//   sram_a/csb/web/oeb/i       macro pins driven by this block
//   sram_o                     macro registered read data
//   idle                       no read in flight and FIFO empty
//   stat_wr_cnt/stat_rd_cnt    accepted write/read counters (0 unless stats enabled)
module gcn_sram_stream_ctrl #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 9,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              idle,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];

  logic              push, pop;
  logic              rd_ok, contend;
  logic              grant_rd, grant_wr;
  logic [CNT_W:0]    credit_use;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    rdata_valid = ~rst & (occ_q != '0);
    pop         = rdata_valid & rdata_ready;
    // Word read in the previous cycle is on sram_o now; a reset drops it.
    push        = inflight_q & ~rst;

    // Slots already claimed: buffered words plus the one in flight, less the
    // one leaving this cycle.
    credit_use  = {1'b0, occ_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    rd_ok       = credit_use < (CNT_W+1)'(OUT_DEPTH);

    contend     = wr_valid & rd_valid & rd_ok;
    grant_rd    = ~rst & rd_valid & rd_ok & (~wr_valid | ~prio_q);
    grant_wr    = ~rst & wr_valid & ~grant_rd;

    wr_ready    = grant_wr;
    rd_ready    = grant_rd;

    prio_d      = (contend & ~rst) ? ~prio_q : prio_q;
    inflight_d  = grant_rd;

    sram_csb    = ~(grant_rd | grant_wr);
    sram_web    = ~grant_wr;
    sram_oeb    = 1'b0;

    a_d         = a_q;
    din_d       = din_q;
    if (grant_wr) begin
      a_d   = wr_addr;
      din_d = wr_data;
    end else if (grant_rd) begin
      a_d   = rd_addr;
    end
    sram_a      = a_d;
    sram_i      = din_d;

    wptr_d      = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d      = pop  ? ptr_inc(rptr_q) : rptr_q;
    occ_d       = occ_q + CNT_W'(push) - CNT_W'(pop);

    rdata       = mem_q[rptr_q];
    idle        = rst | (~inflight_q & (occ_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      prio_q     <= 1'b0;
      a_q        <= '0;
      din_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      prio_q     <= prio_d;
      a_q        <= a_d;
      din_q      <= din_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= sram_o;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ_q == CNT_W'(OUT_DEPTH))));

`ifdef GCN_SRAM_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (grant_wr) stat_wr_q <= stat_wr_q + 32'd1;
      if (grant_rd) stat_rd_q <= stat_rd_q + 32'd1;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif

endmodule

// File: doc/gcn_sram_stream_ctrl.md
Name: gcn_sram_stream_ctrl

Overview:
- Front-end controller for one single-port 512x128 SRAM macro in the GCN datapath (feature/weight buffer).
- Merges a write request stream and a read-address stream onto the macro's single port, one access per cycle.
- Absorbs the macro's 1-cycle registered read latency into a small output FIFO, giving a valid/ready read-data stream with full backpressure.
- The macro is clocked by the same clk; this block drives its chip-select, write-enable, output-enable, address and data pins.

Parameters:
- DATA_W, 128, word width; must match the macro.
- ADDR_W, 9, address width (512 words).
- OUT_DEPTH, 2, output FIFO entries; minimum 2.

Ports:
- clk  in  1  clock; also the macro's CE.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  ADDR_W  read address.
- rdata_valid  out  1  output FIFO head valid.
- rdata_ready  in  1  consumer accepts the head.
- rdata  out  DATA_W  output FIFO head data.
- sram_a  out  ADDR_W  macro address.
- sram_csb  out  1  macro chip select, active low.
- sram_web  out  1  macro write enable, active low.
- sram_oeb  out  1  macro output enable, active low; tied 0.
- sram_i  out  DATA_W  macro write data.
- sram_o  in  DATA_W  macro read data.
- idle  out  1  no read in flight and FIFO empty.
- stat_wr_cnt  out  32  accepted-write counter (optional feature).
- stat_rd_cnt  out  32  accepted-read counter (optional feature).

Behaviour:
- Reset: wr_ready=0, rd_ready=0, sram_csb=1, rdata_valid=0, idle=1 while rst=1.
- Reset also clears FIFO pointers, the occupancy counter, the in-flight flag, the arbiter priority bit and the stat counters.
- Reset during operation drops any in-flight read and all buffered data; SRAM contents are untouched.
- Handshake: a transfer occurs when valid and ready are both high in the same cycle.
  - valid must not depend on ready.
  - wr_ready/rd_ready are combinational from the valids, the credit state and rdata_ready.
- Read credit: rd_ok = (occ + inflight - pop) < OUT_DEPTH.
  - pop = rdata_valid & rdata_ready.
  - inflight = 1 when a read was accepted in the previous cycle.
- Arbitration, when both requests are valid and rd_ok=1:
  - round-robin through priority bit prio (0 = read first); reset value 0.
  - prio toggles to favour the other side after each grant made under contention.
- A single valid request is granted alone; a read is granted only if rd_ok=1.
- If rd_ok=0, a pending write is granted.
- Never more than one grant per cycle.
- Accepted write in cycle t:
  - sram_csb=0, sram_web=0, sram_a=wr_addr, sram_i=wr_data during t.
  - The macro commits the word at the rising edge ending t.
- Accepted read in cycle t:
  - sram_csb=0, sram_web=1, sram_a=rd_addr during t.
  - sram_o holds the word during t+1; the block pushes it into the FIFO at the edge ending t+1.
  - rdata_valid=1 from t+2. Read-data latency is 2 cycles.
- No grant: sram_csb=1; sram_a and sram_i hold their last values.
- Ordering: read data leaves in request order. A read accepted after a write to the same address returns the new data; no hazard logic is needed because the port is serialised.
- Throughput:
  - 1 access/cycle total.
  - Sustained 1 read/cycle when rdata_ready is held 1.
  - The FIFO never overflows by construction; an overflow is an assertion failure.
- FIFO push and pop in the same cycle: occ unchanged. Pointers wrap modulo OUT_DEPTH.
- rdata holds stable while rdata_valid=1 and rdata_ready=0.

Optional Feature:
- Macro: GCN_SRAM_STATS_EN.
- Defined:
  - stat_wr_cnt increments on each accepted write; stat_rd_cnt increments on each accepted read.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on rst.
- Undefined: both ports tie to 0 and no counter flops exist.

Test Plan:
- Write 0xA5..A5 to addr 0x1FF, then read 0x1FF -> rdata=0xA5..A5 two cycles after rd accept; sram_web=0 then 1.
- 8 back-to-back reads of addr 0..7 (prefilled data=addr) with rdata_ready=1 -> rd_ready=1 every cycle; rdata 0..7 on 8 consecutive cycles starting 2 cycles after the first accept.
- Same 8 reads with rdata_ready=0 -> exactly OUT_DEPTH=2 reads accepted, rd_ready=0 afterwards, rdata stable at word 0. Release ready -> remaining words arrive in order.
- wr_valid and rd_valid held high 6 cycles after reset -> grants alternate R,W,R,W,R,W; never both ready in one cycle.
- Assert rst the cycle after a read accept -> next cycle rdata_valid=0, idle=1, sram_csb=1; no stale data appears after reset releases.
- With GCN_SRAM_STATS_EN: 3 writes and 5 reads -> stat_wr_cnt=3, stat_rd_cnt=5. Without the macro: both read 0.
